// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared definitions for the instruction fetch slice.
//   RESET_PC_DEFAULT  : default first fetch address after reset
//   BUF_DEPTH_DEFAULT : default instruction buffer depth (power of two, >= 2)
//   fetch_state_t     : fetch controller states (BOOT, FETCH, FLUSH)
//   fetch_entry_t     : one buffered instruction with its address
//   word_align()      : clears the byte-offset bits of an address
package riscv_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam int          BUF_DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
// Synchronous FIFO holding fetched instructions between the memory
// response path and the decode consumer. Head entry is visible
// combinationally (show-ahead).
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   push_i        : write push_data_i this cycle
//   push_data_i   : entry to write
//   pop_i         : discard the head entry this cycle
//   flush_i       : empty the FIFO; wins over push and pop
//   head_o        : current head entry (undefined content when empty)
//   full_o/empty_o: occupancy flags
//   count_o       : number of valid entries
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter  int DEPTH = BUF_DEPTH_DEFAULT,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  fetch_entry_t  push_data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output fetch_entry_t  head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_pop_ok;
    logic w_push_ok;

    assign empty_o = (r_count == '0);
    assign full_o  = (r_count == CW'(DEPTH));
    assign count_o = r_count;
    assign head_o  = r_mem[r_rd_ptr];

    // A push into a full FIFO is accepted only when the head leaves in the
    // same cycle, which keeps occupancy constant.
    assign w_pop_ok  = pop_i & ~empty_o;
    assign w_push_ok = push_i & (~full_o | w_pop_ok);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (w_push_ok && !flush_i) begin
            r_mem[r_wr_ptr] <= push_data_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch front end: issues sequential word fetches to the
// instruction memory, buffers responses with their addresses, and hands
// them to decode. A redirect strobe restarts fetch at a new target and
// throws away everything fetched on the old path.
//
// Handshakes (both directions use the same rule): a transfer happens in
// a cycle where valid and ready/grant are both high. Once imem_req_o is
// raised, it and imem_addr_o stay put until imem_gnt_i, except that a
// redirect withdraws the request. inst_valid_o/inst_o/pc_o stay put until
// inst_ready_i, except that a redirect flushes them. Responses
// (imem_rvalid_i) return in request order with no back-pressure.
//
// Ports:
//   clk, rst                  : clock, asynchronous active-low reset
//   imem_req_o, imem_addr_o   : fetch request and word address
//   imem_gnt_i                : memory accepts the request this cycle
//   imem_rvalid_i/_rdata_i    : in-order response and instruction word
//   pc_sel_i, target_i        : redirect strobe and target address
//   inst_o, pc_o, inst_valid_o: buffered instruction to decode
//   inst_ready_i              : decode takes inst_o this cycle
//   dbg_state_o               : current controller state, for observation
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = BUF_DEPTH_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    output logic         imem_req_o,
    output logic [31:0]  imem_addr_o,
    input  logic         imem_gnt_i,
    input  logic         imem_rvalid_i,
    input  logic [31:0]  imem_rdata_i,
    input  logic         pc_sel_i,
    input  logic [31:0]  target_i,
    output logic [31:0]  inst_o,
    output logic [31:0]  pc_o,
    output logic         inst_valid_o,
    input  logic         inst_ready_i,
    output fetch_state_t dbg_state_o
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;  // counters reach BUF_DEPTH
    localparam int SW = CW + 1;                 // credit sum reaches 2*BUF_DEPTH

    fetch_state_t  r_state;
    logic [31:0]   r_fetch_pc;     // address of the next request
    logic [31:0]   r_resp_pc;      // address of the next kept response
    logic [CW-1:0] r_outstanding;  // granted requests not yet answered
    logic [CW-1:0] r_discard;      // responses still to be thrown away

    fetch_state_t  w_state_next;
    logic          w_redirect;
    logic          w_pop;
    logic          w_req;
    logic          w_fire;
    logic          w_rv_acc;
    logic          w_drop;
    logic          w_push;
    logic [SW-1:0] w_credit_used;
    logic [CW-1:0] w_outstanding_next;
    logic [CW-1:0] w_discard_next;

    fetch_entry_t  w_push_entry;
    fetch_entry_t  w_head;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [CW-1:0] w_fifo_count;

    // Redirects are meaningless before the first fetch address is live.
    assign w_redirect = pc_sel_i & (r_state != ST_BOOT);

    // Flush wins over a pop in the same cycle.
    assign w_pop = ~w_fifo_empty & inst_ready_i & ~w_redirect;

    // Every in-flight request owns a buffer slot. A pop this cycle frees a
    // slot early so a full pipeline can sustain one fetch per cycle.
    assign w_credit_used = SW'(r_outstanding) + SW'(w_fifo_count) - SW'(w_pop);

    assign w_req  = (r_state == ST_FETCH) & ~w_redirect
                  & (w_credit_used < SW'(BUF_DEPTH));
    assign w_fire = w_req & imem_gnt_i;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_rv_acc = imem_rvalid_i & (r_outstanding != '0);

    // Responses belonging to the old path are dropped: those still being
    // discarded and the one arriving in the redirect cycle itself.
    assign w_drop = w_rv_acc & (w_redirect | (r_discard != '0));
    assign w_push = w_rv_acc & ~w_drop & (~w_fifo_full | w_pop);

    assign w_push_entry.pc   = r_resp_pc;
    assign w_push_entry.inst = imem_rdata_i;

    always_comb begin
        w_outstanding_next = r_outstanding;
        case ({w_fire, w_rv_acc})
            2'b10:   w_outstanding_next = r_outstanding + CW'(1);
            2'b01:   w_outstanding_next = r_outstanding - CW'(1);
            default: w_outstanding_next = r_outstanding;
        endcase
    end

    // On a redirect every request still in flight after this cycle is
    // stale, so the discard count is simply the next outstanding count.
    // While flushing no new requests go out, so the two stay equal.
    always_comb begin
        w_discard_next = r_discard;
        if (w_redirect) begin
            w_discard_next = w_outstanding_next;
        end else if (w_rv_acc && (r_discard != '0)) begin
            w_discard_next = r_discard - CW'(1);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_BOOT: begin
                w_state_next = ST_FETCH;
            end
            ST_FETCH, ST_FLUSH: begin
                if (w_redirect) begin
                    w_state_next = (w_discard_next != '0) ? ST_FLUSH : ST_FETCH;
                end else if ((r_state == ST_FLUSH) && (w_discard_next == '0)) begin
                    w_state_next = ST_FETCH;
                end
            end
            default: begin
                w_state_next = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_BOOT;
            r_fetch_pc    <= word_align(RESET_PC);
            r_resp_pc     <= word_align(RESET_PC);
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_state       <= w_state_next;
            r_outstanding <= w_outstanding_next;
            r_discard     <= w_discard_next;

            // Address wraps naturally from 32'hFFFF_FFFC to 32'h0.
            if (w_redirect) begin
                r_fetch_pc <= word_align(target_i);
            end else if (w_fire) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end

            // All kept responses after a redirect come from requests issued
            // sequentially from the target, so their addresses follow suit.
            if (w_redirect) begin
                r_resp_pc <= word_align(target_i);
            end else if (w_push) begin
                r_resp_pc <= r_resp_pc + 32'd4;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (w_push),
        .push_data_i (w_push_entry),
        .pop_i       (w_pop),
        .flush_i     (w_redirect),
        .head_o      (w_head),
        .full_o      (w_fifo_full),
        .empty_o     (w_fifo_empty),
        .count_o     (w_fifo_count)
    );

    assign imem_req_o   = w_req;
    assign imem_addr_o  = r_fetch_pc;
    assign inst_valid_o = ~w_fifo_empty;
    assign inst_o       = w_fifo_empty ? 32'h0 : w_head.inst;
    assign pc_o         = w_fifo_empty ? 32'h0 : w_head.pc;
    assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Directed scenarios plus randomized traffic for fetch_unit. A memory
// environment answers granted requests in order after a programmable
// latency; a transaction-level reference model (queues of in-flight
// requests and of deliverable instructions) predicts every output each
// cycle.
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam int          DEPTH = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         imem_req_o;
    logic [31:0]  imem_addr_o;
    logic         imem_gnt_i;
    logic         imem_rvalid_i;
    logic [31:0]  imem_rdata_i;
    logic         pc_sel_i;
    logic [31:0]  target_i;
    logic [31:0]  inst_o;
    logic [31:0]  pc_o;
    logic         inst_valid_o;
    logic         inst_ready_i;
    fetch_state_t dbg_state_o;

    fetch_unit #(
        .RESET_PC  (RPC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .pc_sel_i      (pc_sel_i),
        .target_i      (target_i),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .inst_valid_o  (inst_valid_o),
        .inst_ready_i  (inst_ready_i),
        .dbg_state_o   (dbg_state_o)
    );

    // ---------------- environment and model state ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          due;
        bit          orphan;
    } mem_t;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } infl_t;

    mem_t        mem_q[$];   // memory: granted requests awaiting response
    infl_t       infl_q[$];  // model: requests the fetch unit is waiting on
    logic [63:0] exp_q[$];   // model: {pc, inst} deliverable to decode, in order

    logic [31:0] fire_q[$];
    int          fire_cyc_q[$];
    logic [31:0] pop_pc_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int seq    = 0;
    int last_due = 0;

    int gnt_pct   = 100;
    int ready_pct = 100;
    int lat_min   = 1;
    int lat_max   = 1;
    int redir_pm  = 0;

    bit          force_redir = 1'b0;
    logic [31:0] force_tgt   = 32'h0;
    bit          m_in_reset  = 1'b1;
    bit          m_boot      = 1'b0;
    bit          release_pending = 1'b0;
    logic [31:0] m_pc        = RPC;

    int          first_valid_cyc = 0;
    logic [31:0] first_valid_pc  = 32'h0;
    int          pops_seen       = 0;
    int          rel_cyc         = 0;

    // ---------------- scoreboard compare ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic knobs(input int g, input int r, input int lmin, input int lmax, input int rp);
        gnt_pct   = g;
        ready_pct = r;
        lat_min   = lmin;
        lat_max   = lmax;
        redir_pm  = rp;
    endtask

    // ---------------- one clock cycle: drive, check, update ----------------
    task automatic do_cycle();
        bit          rv;
        bit          redir;
        bit          do_redir;
        bit          pop;
        bit          exp_req;
        bit          exp_v;
        bit          stale;
        bit          orphan;
        logic [63:0] head;
        infl_t       r;
        infl_t       e;
        mem_t        m;
        int          due;

        if (release_pending) begin
            rst             = 1'b1;
            release_pending = 1'b0;
            m_in_reset      = 1'b0;
            m_boot          = 1'b1;
        end

        rv = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        orphan = 1'b0;
        foreach (mem_q[i]) if (mem_q[i].orphan) orphan = 1'b1;
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? mem_q[0].data : $urandom();
        imem_gnt_i    = !orphan && (int'($urandom_range(99)) < gnt_pct);
        inst_ready_i  = int'($urandom_range(99)) < ready_pct;
        redir         = force_redir || (int'($urandom_range(999)) < redir_pm);
        pc_sel_i      = redir;
        target_i      = force_redir ? force_tgt : $urandom();
        force_redir   = 1'b0;
        #1;

        if (m_in_reset) begin
            exp_req  = 1'b0;
            exp_v    = 1'b0;
            head     = 64'h0;
            pop      = 1'b0;
            do_redir = 1'b0;
        end else begin
            exp_v = exp_q.size() != 0;
            head  = exp_v ? exp_q[0] : 64'h0;
            stale = 1'b0;
            foreach (infl_q[i]) if (infl_q[i].stale) stale = 1'b1;
            do_redir = redir && !m_boot;
            pop      = exp_v && inst_ready_i && !do_redir;
            exp_req  = !m_boot && !stale && !do_redir
                     && (infl_q.size() + exp_q.size() - int'(pop) < DEPTH);
        end

        check("req",        imem_req_o,   exp_req);
        check("addr",       imem_addr_o,  m_pc);
        check("inst_valid", inst_valid_o, exp_v);
        check("pc",         pc_o,         head[63:32]);
        check("inst",       inst_o,       head[31:0]);

        if (inst_valid_o && (first_valid_cyc < 0)) begin
            first_valid_cyc = cyc;
            first_valid_pc  = pc_o;
        end
        if (inst_valid_o && inst_ready_i && !pc_sel_i) begin
            pops_seen++;
            pop_pc_q.push_back(pc_o);
        end
        if (imem_req_o && imem_gnt_i) begin
            fire_q.push_back(imem_addr_o);
            fire_cyc_q.push_back(cyc);
        end

        // reference model update
        if (!m_in_reset) begin
            if (rv && (infl_q.size() > 0)) begin
                r = infl_q.pop_front();
                if (!r.stale && !do_redir) exp_q.push_back({r.addr, imem_rdata_i});
            end
            if (pop) void'(exp_q.pop_front());
            if (do_redir) begin
                exp_q.delete();
                foreach (infl_q[i]) infl_q[i].stale = 1'b1;
                m_pc = target_i & 32'hFFFF_FFFC;
            end
            if (exp_req && imem_gnt_i) begin
                e.addr  = m_pc;
                e.stale = 1'b0;
                infl_q.push_back(e);
                m_pc = m_pc + 32'd4;
            end
            m_boot = 1'b0;
        end

        // memory environment update
        if (rv) void'(mem_q.pop_front());
        if (imem_req_o && imem_gnt_i) begin
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            m.addr   = imem_addr_o;
            m.data   = {imem_addr_o[15:0] ^ 16'hC3A5, seq[15:0]};
            m.due    = due;
            m.orphan = 1'b0;
            seq++;
            mem_q.push_back(m);
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) do_cycle();
    endtask

    // Holds reset for n checked cycles; the following cycle releases it.
    // Responses still owed by memory arrive only after release.
    task automatic do_reset(input int n);
        int j;
        rst = 1'b0;
        j = 0;
        foreach (mem_q[i]) begin
            mem_q[i].orphan = 1'b1;
            mem_q[i].due    = cyc + n + 1 + j;
            last_due        = mem_q[i].due;
            j++;
        end
        infl_q.delete();
        exp_q.delete();
        m_in_reset = 1'b1;
        m_pc       = RPC;
        run(n);
        release_pending = 1'b1;
    endtask

    task automatic wait_outstanding(input int n);
        int k;
        k = 0;
        while ((infl_q.size() != n) && (k < 50)) begin
            do_cycle();
            k++;
        end
        check("wait_outstanding_timeout", infl_q.size(), n);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst           = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        pc_sel_i      = 1'b0;
        target_i      = 32'h0;
        inst_ready_i  = 1'b0;
        @(posedge clk);
        #1;

        // reset values, then streaming with 1-cycle memory
        knobs(100, 100, 1, 1, 0);
        do_reset(2);
        check("reset_state", dbg_state_o, ST_BOOT);
        fire_q.delete();
        fire_cyc_q.delete();
        first_valid_cyc = -1;
        rel_cyc = cyc;
        run(12);
        check("boot_first_valid_latency", first_valid_cyc - rel_cyc, 3);
        check("boot_first_valid_pc", first_valid_pc, RPC);
        check("boot_fire_count", fire_q.size() >= 6, 1);
        if (fire_q.size() >= 6) begin
            for (int i = 0; i < 6; i++) begin
                check("boot_fire_addr", fire_q[i], RPC + 32'(4 * i));
                check("boot_fire_cycle", fire_cyc_q[i] - rel_cyc, 1 + i);
            end
        end

        // consumer stalls: buffer fills, requests stop, then drain in order
        knobs(100, 0, 1, 1, 0);
        run(10);
        check("stall_req_low", imem_req_o, 1'b0);
        check("stall_valid", inst_valid_o, 1'b1);
        knobs(0, 100, 1, 1, 0);
        pops_seen = 0;
        pop_pc_q.delete();
        run(8);
        check("stall_drained", pops_seen, DEPTH);
        if (pop_pc_q.size() == DEPTH) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                check("stall_drain_seq", pop_pc_q[i + 1], pop_pc_q[i] + 32'd4);
            end
        end

        // redirect with two responses outstanding
        knobs(100, 100, 2, 2, 0);
        wait_outstanding(2);
        fire_q.delete();
        force_redir = 1'b1;
        force_tgt   = 32'h0000_0102;
        do_cycle();
        check("redir_flush_state", dbg_state_o, ST_FLUSH);
        first_valid_cyc = -1;
        run(10);
        check("redir_first_fire", fire_q.size() > 0 ? fire_q[0] : 32'hDEAD_BEEF, 32'h0000_0100);
        check("redir_first_pc", first_valid_pc, 32'h0000_0100);

        // address wrap
        knobs(100, 100, 1, 1, 0);
        run(4);
        fire_q.delete();
        force_redir = 1'b1;
        force_tgt   = 32'hFFFF_FFF8;
        do_cycle();
        run(8);
        check("wrap_count", fire_q.size() >= 3, 1);
        if (fire_q.size() >= 3) begin
            check("wrap_addr0", fire_q[0], 32'hFFFF_FFF8);
            check("wrap_addr1", fire_q[1], 32'hFFFF_FFFC);
            check("wrap_addr2", fire_q[2], 32'h0000_0000);
        end

        // redirect coincident with a response and an offered grant
        run(3);
        force_redir = 1'b1;
        force_tgt   = 32'h0000_2003;
        do_cycle();
        first_valid_cyc = -1;
        run(6);
        check("coincident_first_pc", first_valid_pc, 32'h0000_2000);

        // same with deeper latency so the discard count is nonzero
        knobs(100, 100, 3, 3, 0);
        run(6);
        force_redir = 1'b1;
        force_tgt   = 32'h0000_3000;
        do_cycle();
        first_valid_cyc = -1;
        run(10);
        check("deep_first_pc", first_valid_pc, 32'h0000_3000);

        // reset with three responses outstanding; they arrive after release
        wait_outstanding(3);
        do_reset(2);
        fire_q.delete();
        first_valid_cyc = -1;
        run(20);
        check("rst_mid_first_fire", fire_q.size() > 0 ? fire_q[0] : 32'hDEAD_BEEF, RPC);
        check("rst_mid_first_pc", first_valid_pc, RPC);

        // randomized traffic with random redirects and a mid-run reset
        knobs(70, 60, 1, 4, 40);
        run(1500);
        do_reset(2);
        knobs(60, 80, 1, 3, 25);
        run(500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
